mem_arbiter: RTL and testbench

- Two-requester round-robin arbiter and burst sequencer in front of the single-port word memory: waddr/wdata/wen, raddr/ren/rdata, 1-cycle registered read.
- Grants one requester at a time and issues one word access per cycle for a burst of len words.
- Returns read data tagged to the owner and pulses done on completion.
- Guarantees ren and wen are never asserted together.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and burst sequencer in front of a single-port word memory.
// Issues one access per cycle for the granted burst; read data returns one cycle after each beat.
module mem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [LW-1:0] a_len,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_beat,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_done,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [LW-1:0] b_len,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_beat,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_done,
  output logic          m_ren,
  output logic [AW-1:0] m_raddr,
  output logic          m_wen,
  output logic [AW-1:0] m_waddr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 0 = A, 1 = B
  logic          rr_q, rr_d;        // requester that wins the next tie
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;

  logic [LW-1:0] req_len;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    req_len  = '0;
    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          owner_d = b_req && (!a_req || rr_q);
          rr_d    = ~owner_d;
          we_d    = owner_d ? b_we : a_we;
          addr_d  = owner_d ? b_addr : a_addr;
          req_len = owner_d ? b_len : a_len;
          cnt_d   = (req_len == '0) ? LW'(1) : req_len;
          state_d = StBurst;
        end
      end
      StBurst: begin
        addr_d   = addr_q + AW'(1);
        cnt_d    = cnt_q - LW'(1);
        rvalid_d = ~we_q;
        if (cnt_q == LW'(1)) begin
          state_d = we_q ? StDone : StDrain;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  logic busy, burst;
  assign busy  = (state_q != StIdle);
  assign burst = (state_q == StBurst);

  assign a_gnt  = busy & ~owner_q;
  assign b_gnt  = busy & owner_q;
  assign a_beat = burst & ~owner_q;
  assign b_beat = burst & owner_q;
  assign a_done = (state_q == StDone) & ~owner_q;
  assign b_done = (state_q == StDone) & owner_q;

  // Memory returns data the cycle after m_ren, which is exactly when rvalid_q is set.
  assign a_rvalid = rvalid_q & ~owner_q;
  assign b_rvalid = rvalid_q & owner_q;
  assign a_rdata  = a_rvalid ? m_rdata : '0;
  assign b_rdata  = b_rvalid ? m_rdata : '0;

  assign m_ren   = burst & ~we_q;
  assign m_wen   = burst & we_q;
  assign m_raddr = burst ? addr_q : '0;
  assign m_waddr = burst ? addr_q : '0;
  assign m_wdata = m_wen ? (owner_q ? b_wdata : a_wdata) : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word memory (preloaded mem[i] = i).
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [LW-1:0] a_len, b_len;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_beat, a_rvalid, a_done;
  logic          b_gnt, b_beat, b_rvalid, b_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          m_ren, m_wen;
  logic [AW-1:0] m_raddr, m_waddr;
  logic [DW-1:0] m_wdata, m_rdata;

  mem_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_len(a_len), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_beat(a_beat), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_done(a_done),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_beat(b_beat), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_done(b_done),
    .m_ren(m_ren), .m_raddr(m_raddr), .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (m_wen) mem[m_waddr] = m_wdata;
    if (m_ren) m_rdata <= mem[m_raddr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;
  always @(negedge clk) if (m_ren && m_wen) overlap++;

  wire any_out = |{a_gnt, a_beat, a_rvalid, a_rdata, a_done, b_gnt, b_beat, b_rvalid, b_rdata,
                   b_done, m_ren, m_raddr, m_wen, m_waddr, m_wdata};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_rdata[$];
  int            done_cyc, side, wd_bad;

  // Runs one burst for requester who; cycle 1 is the first cycle after the grant edge.
  task automatic run_burst(input logic who, input logic we, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input logic [DW-1:0] wbase);
    int nb;
    logic ob, orv, od, oth;
    logic [DW-1:0] ord;
    q_addr.delete();
    q_rdata.delete();
    done_cyc = 0; side = 0; wd_bad = 0; nb = 0;
    if (who) begin b_req = 1; b_we = we; b_addr = addr; b_len = len; end
    else     begin a_req = 1; a_we = we; a_addr = addr; a_len = len; end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (who) b_wdata = wbase + DW'(nb); else a_wdata = wbase + DW'(nb);
      @(negedge clk);
      ob  = who ? b_beat : a_beat;
      orv = who ? b_rvalid : a_rvalid;
      ord = who ? b_rdata : a_rdata;
      od  = who ? b_done : a_done;
      oth = who ? (a_gnt | a_beat | a_rvalid | a_done | (|a_rdata))
                : (b_gnt | b_beat | b_rvalid | b_done | (|b_rdata));
      if (oth) side++;
      if (ob) begin
        q_addr.push_back(we ? m_waddr : m_raddr);
        if (m_wdata !== (we ? wbase + DW'(nb) : '0)) wd_bad++;
        nb++;
      end
      if (orv) q_rdata.push_back(ord);
      if (od) begin
        done_cyc = cyc;
        break;
      end
    end
    a_req = 0;
    b_req = 0;
    @(negedge clk);
    check("gnt_drop", 64'(who ? b_gnt : a_gnt), 64'(0));
  endtask

  logic [3:0]    seq;
  int            nseen, c1, c2;
  logic [AW-1:0] e_addr[4];

  initial begin
    rst = 1;
    a_req = 0; a_we = 0; a_addr = '0; a_len = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_len = '0; b_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    repeat (2) @(negedge clk);
    check("rst_outs", 64'(any_out), 64'(0));
    rst = 0;
    @(negedge clk);
    check("idle_outs", 64'(any_out), 64'(0));

    // Tie from reset with both held: A, B, A, B, one IDLE cycle between bursts
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    a_addr = 16'h0040; b_addr = 16'h0050; a_len = 8'd1; b_len = 8'd1;
    seq = '0; nseen = 0; c1 = 0; c2 = 0;
    for (int c = 1; c <= 30 && nseen < 4; c++) begin
      @(negedge clk);
      if (a_beat || b_beat) begin
        seq = {seq[2:0], b_beat};
        if (nseen == 0) c1 = c;
        if (nseen == 1) c2 = c;
        nseen++;
      end
    end
    a_req = 0; b_req = 0;
    check("rr_order", 64'(seq), 64'(4'b0101));
    check("rr_first_cyc", 64'(c1), 64'(1));
    check("rr_second_cyc", 64'(c2), 64'(5));
    repeat (4) @(negedge clk);

    // Read A at 4, three words
    run_burst(1'b0, 1'b0, 16'd4, 8'd3, '0);
    check("rdA_nbeats", 64'(q_addr.size()), 64'(3));
    check("rdA_nrv", 64'(q_rdata.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rdA_addr%0d", i), 64'(q_addr[i]), 64'(4 + i));
      check($sformatf("rdA_data%0d", i), 64'(q_rdata[i]), 64'(4 + i));
    end
    check("rdA_done_cyc", 64'(done_cyc), 64'(5));
    check("rdA_b_quiet", 64'(side), 64'(0));

    // Write B at 100, two words, then read them back
    run_burst(1'b1, 1'b1, 16'd100, 8'd2, 32'hAAAA0001);
    check("wrB_nbeats", 64'(q_addr.size()), 64'(2));
    check("wrB_addr0", 64'(q_addr[0]), 64'(100));
    check("wrB_addr1", 64'(q_addr[1]), 64'(101));
    check("wrB_wdata", 64'(wd_bad), 64'(0));
    check("wrB_nrv", 64'(q_rdata.size()), 64'(0));
    check("wrB_done_cyc", 64'(done_cyc), 64'(3));
    check("wrB_a_quiet", 64'(side), 64'(0));

    run_burst(1'b1, 1'b0, 16'd100, 8'd2, '0);
    check("rdB_nrv", 64'(q_rdata.size()), 64'(2));
    check("rdB_data0", 64'(q_rdata[0]), 64'(32'hAAAA0001));
    check("rdB_data1", 64'(q_rdata[1]), 64'(32'hAAAA0002));
    check("rdB_done_cyc", 64'(done_cyc), 64'(4));

    // Address wrap
    run_burst(1'b0, 1'b0, 16'hFFFE, 8'd4, '0);
    e_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    check("wrap_nbeats", 64'(q_addr.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_addr%0d", i), 64'(q_addr[i]), 64'(e_addr[i]));
      check($sformatf("wrap_data%0d", i), 64'(q_rdata[i]), 64'(e_addr[i]));
    end
    check("wrap_done_cyc", 64'(done_cyc), 64'(6));

    // Zero length behaves as one
    run_burst(1'b0, 1'b0, 16'd7, 8'd0, '0);
    check("len0_nbeats", 64'(q_addr.size()), 64'(1));
    check("len0_nrv", 64'(q_rdata.size()), 64'(1));
    check("len0_data", 64'(q_rdata[0]), 64'(7));
    check("len0_done_cyc", 64'(done_cyc), 64'(3));

    // Reset during beat 2 of a five-word read; B waits and is served after release
    a_req = 1; a_we = 0; a_addr = 16'h0020; a_len = 8'd5;
    @(negedge clk);
    check("mr_beat1", 64'(a_beat), 64'(1));
    check("mr_addr1", 64'(m_raddr), 64'(16'h0020));
    b_req = 1; b_we = 0; b_addr = 16'h0030; b_len = 8'd1;
    @(negedge clk);
    check("mr_addr2", 64'(m_raddr), 64'(16'h0021));
    rst = 1; a_req = 0;
    #1;
    check("mr_rst_outs", 64'(any_out), 64'(0));
    @(negedge clk);
    check("mr_rst_hold", 64'(any_out), 64'(0));
    rst = 0;
    @(negedge clk);
    check("mr_b_beat", 64'(b_beat), 64'(1));
    check("mr_b_addr", 64'(m_raddr), 64'(16'h0030));
    check("mr_a_rv0", 64'(a_rvalid), 64'(0));
    @(negedge clk);
    check("mr_b_rv", 64'(b_rvalid), 64'(1));
    check("mr_b_data", 64'(b_rdata), 64'(32'h0000_0030));
    check("mr_a_rv1", 64'(a_rvalid), 64'(0));
    @(negedge clk);
    check("mr_b_done", 64'(b_done), 64'(1));
    b_req = 0;
    @(negedge clk);
    check("mr_b_gnt_drop", 64'(b_gnt), 64'(0));

    check("ren_wen_overlap", 64'(overlap), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
